// File: rtl/irq_ctrl.sv
// irq_ctrl: six-source interrupt controller with mask, per-source edge/level
// mode, pending and in-service registers, and a three-state request FSM that
// issues one request at a time to CP0 and waits for an EOI before the next.
module irq_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:2] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   input  logic [5:0]  irq_in,
   output logic        int_req,
   output logic [2:0]  int_id,
   input  logic        int_ack
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_SERV = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  mask_q, mask_d;
   logic [5:0]  mode_q, mode_d;
   logic [5:0]  pend_q, pend_d;
   logic [5:0]  insv_q, insv_d;
   logic [5:0]  prev_q;
   logic        int_req_q, int_req_d;
   logic [2:0]  int_id_q, int_id_d;

   logic [1:0]  sel;
   logic        wr_mask, wr_mode, wr_pend, wr_insv;
   logic [5:0]  w1c, edge_set, eligible, ack_onehot, ack_clr;
   logic [2:0]  winner;

   // Only Addr[3:2] and Din[5:0] carry meaning; the rest is deliberately dropped.
   logic        unused_bits;
   assign unused_bits = ^{Addr[31:4], Din[31:6]};

   assign sel      = Addr[3:2];
   assign wr_mask  = WE && (sel == 2'd0);
   assign wr_mode  = WE && (sel == 2'd1);
   assign wr_pend  = WE && (sel == 2'd2);
   assign wr_insv  = WE && (sel == 2'd3);

   assign w1c        = wr_pend ? Din[5:0] : 6'd0;
   assign edge_set   = irq_in & ~prev_q;
   assign eligible   = pend_q & mask_q;
   assign ack_onehot = 6'd1 << int_id_q;

   // Fixed priority: lowest-index eligible source wins.
   always_comb begin
      winner = 3'd0;
      for (int i = 5; i >= 0; i--) begin
         if (eligible[i]) winner = 3'(i);
      end
   end

   // Request FSM next state; arbitration only happens from IDLE, so a latched
   // request is never preempted by a higher-priority arrival.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // that no path leaves it unassigned and infers a latch.
      state_d   = state_q;
      int_req_d = int_req_q;
      int_id_d  = int_id_q;
      insv_d    = insv_q;
      ack_clr   = 6'd0;
      unique case (state_q)
         ST_IDLE: begin
            if ((eligible != 6'd0) && (insv_q == 6'd0)) begin
               state_d   = ST_REQ;
               int_req_d = 1'b1;
               int_id_d  = winner;
            end
         end
         ST_REQ: begin
            if (int_ack) begin
               insv_d    = insv_q | ack_onehot;
               ack_clr   = ack_onehot;
               int_req_d = 1'b0;
               state_d   = ST_SERV;
            end else if ((eligible & ack_onehot) == 6'd0) begin
               int_req_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         ST_SERV: begin
            if (wr_insv) begin
               insv_d  = 6'd0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Configuration writes and pending update: edge bits set on a rising edge
   // (set beats W1C/ack clear), level bits simply follow the raw line.
   always_comb begin
      mask_d = wr_mask ? Din[5:0] : mask_q;
      mode_d = wr_mode ? Din[5:0] : mode_q;
      pend_d = (mode_q & (edge_set | (pend_q & ~(w1c | ack_clr))))
             | (~mode_q & irq_in);
   end

   // Combinational register read, zero-extended to 32 bits.
   always_comb begin
      Dout = 32'd0;
      unique case (sel)
         2'd0: Dout[5:0] = mask_q;
         2'd1: Dout[5:0] = mode_q;
         2'd2: Dout[5:0] = pend_q;
         2'd3: Dout[5:0] = insv_q;
         default: Dout = 32'd0;
      endcase
   end

   // State registers with synchronous reset overriding every other input.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         state_q   <= ST_IDLE;
         mask_q    <= 6'd0;
         mode_q    <= 6'd0;
         pend_q    <= 6'd0;
         insv_q    <= 6'd0;
         prev_q    <= 6'd0;
         int_req_q <= 1'b0;
         int_id_q  <= 3'd0;
      end else begin
         state_q   <= state_d;
         mask_q    <= mask_d;
         mode_q    <= mode_d;
         pend_q    <= pend_d;
         insv_q    <= insv_d;
         prev_q    <= irq_in;
         int_req_q <= int_req_d;
         int_id_q  <= int_id_d;
      end
   end

   assign int_req = int_req_q;
   assign int_id  = int_id_q;

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 Addr  input  30 [31:2]  word address; only Addr[3:2] SHALL be decoded.
REQ-004 WE  input  1  register write enable.
REQ-005 Din  input  32  write data.
REQ-006 Dout  output  32  combinational register read data.
REQ-007 irq_in  input  6  raw interrupt lines; bit 0 is timer 0, bit 1 is timer 1, bits 5:2 are external; bit 0 is highest priority.
REQ-008 int_req  output  1  registered interrupt request to CP0.
REQ-009 int_id  output  3  registered index of the requested source, valid while int_req=1.
REQ-010 int_ack  input  1  one-cycle pulse from CP0 accepting the current request.

Function
REQ-011 Register map by Addr[3:2]: 0 MASK, 1 MODE, 2 PEND, 3 INSV; each SHALL be 6 bits, and Dout SHALL be zero-extended to 32 bits.
REQ-012 MASK write SHALL load Din[5:0]; bit=1 enables the source.
REQ-013 MODE write SHALL load Din[5:0]; bit=1 selects edge mode, bit=0 selects level mode.
REQ-014 A PEND write SHALL be write-1-to-clear on edge-mode bits and SHALL be ignored on level-mode bits.
REQ-015 Any INSV write SHALL be an EOI: it SHALL clear all INSV bits and move the FSM from SERV to IDLE; in any other state it SHALL be ignored.
REQ-016 Edge detect: prev <= irq_in every cycle; prev SHALL be 0 after reset.
REQ-017 Edge-mode PEND[i] SHALL set on irq_in[i] & ~prev[i], and SHALL clear on W1C or on ack of source i; if set and clear coincide, set SHALL win.
REQ-018 Level-mode PEND[i] SHALL register irq_in[i] every cycle.
REQ-019 eligible = PEND & MASK; the winner SHALL be the lowest-index eligible bit.
REQ-020 FSM states: IDLE, REQ, SERV.
REQ-021 IDLE: if eligible != 0 and INSV == 0, the FSM SHALL go to REQ, latch int_id = winner and set int_req = 1 on the same edge.
REQ-022 REQ, int_ack=1: the FSM SHALL set INSV[int_id], clear PEND[int_id] if edge mode, drop int_req, and go to SERV.
REQ-023 REQ, int_ack=0, and eligible[int_id]=0 (masked or cleared): the FSM SHALL drop int_req and go to IDLE; re-arbitration SHALL occur no earlier than the next cycle.
REQ-024 REQ, int_ack=0, eligible[int_id]=1: int_req and int_id SHALL hold, and a higher-priority arrival SHALL NOT preempt the latched int_id.
REQ-025 SERV: no new request SHALL issue; pending bits SHALL continue to accumulate; the FSM SHALL leave SERV only on EOI.
REQ-026 int_ack outside REQ SHALL be ignored.
REQ-027 A register write and an ack in the same cycle SHALL both take effect; for PEND, ack-clear and W1C SHALL OR together.
REQ-028 Request latency: an edge on irq_in at cycle N SHALL set PEND at N+1 and drive int_req=1 at N+2.

Reset
REQ-029 On reset, MASK, MODE, PEND, INSV, prev, int_req and int_id SHALL be 0, and the FSM SHALL be in IDLE.
REQ-030 Reset SHALL take precedence over WE, int_ack and irq_in, including mid-REQ or mid-SERV.

Verification
REQ-031 MASK=0x3F, MODE=0x3F, irq_in[1] 0->1 at cycle N -> PEND=0x02 at N+1, int_req=1 with int_id=1 at N+2.
REQ-032 Edge mode, irq_in bits 3 and 0 rise together -> int_id=0; int_ack -> INSV=0x01, PEND=0x08; write INSV -> IDLE, then int_id=3 two cycles later.
REQ-033 MODE=0 (level), irq_in[2] held high, ack then EOI -> PEND[2] stays 1 and a new request for id 2 issues after EOI; W1C to PEND bit 2 has no effect.
REQ-034 In REQ with int_id=4, write MASK=0x2F -> int_req=0 the next cycle and the FSM returns to IDLE.
REQ-035 Edge mode, W1C PEND bit 1 in the same cycle a new edge arrives on irq_in[1] -> PEND[1]=1.
REQ-036 Assert reset while in SERV with PEND=0x3F -> all registers read 0 and int_req=0.
